pc_ctrl: RTL and testbench

Program-counter and fetch-redirect stage that sits directly downstream of the branch condition checker. It consumes the `taken` decision together with the jump qualifier and target, advances or redirects the PC, and squashes wrong-path instructions with a fixed-length flush window. It also stalls on back-pressure and halts on request, and it drives the instruction-memory fetch address and fetch-valid signal.

---
 rtl/pc_ctrl_if.sv | 60 ++++++
 rtl/pc_ctrl.sv | 154 +++++++++++++++
 tb/tb_pc_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_ctrl_if
//
// Groups the resolve-stage inputs and the fetch-side outputs of pc_ctrl.
//
//   master : the resolve stage / environment driving pc_ctrl
//   slave  : pc_ctrl itself
//
// Signals (direction as seen by pc_ctrl):
//   is_jmp_op   in   instruction in resolve is a jump
//   taken       in   condition-checker result, qualified by is_jmp_op
//   jmp_target  in   jump destination
//   stall       in   downstream back-pressure, holds the PC
//   halt        in   request to stop fetching
//   fetch_addr  out  registered PC driven to instruction memory
//   fetch_valid out  fetch_addr is a live fetch
//   flush       out  squash younger in-flight instructions
//   halted      out  block is parked in HALT
//   link_addr   out  return address captured on redirect (0 when disabled)
// ---------------------------------------------------------------------------
interface pc_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  is_jmp_op;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] jmp_target;
    logic                  stall;
    logic                  halt;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_valid;
    logic                  flush;
    logic                  halted;
    logic [ADDR_WIDTH-1:0] link_addr;

    modport master (
        output is_jmp_op,
        output taken,
        output jmp_target,
        output stall,
        output halt,
        input  fetch_addr,
        input  fetch_valid,
        input  flush,
        input  halted,
        input  link_addr
    );

    modport slave (
        input  is_jmp_op,
        input  taken,
        input  jmp_target,
        input  stall,
        input  halt,
        output fetch_addr,
        output fetch_valid,
        output flush,
        output halted,
        output link_addr
    );
endinterface

// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl
//
// Program-counter and fetch-redirect stage. Sits downstream of the branch
// condition checker: advances the PC, redirects it on a taken jump, opens a
// fixed-length squash window after each redirect, holds on back-pressure and
// parks permanently on a halt request.
//
// Parameters:
//   ADDR_WIDTH   PC / instruction-address width
//   RESET_VECTOR PC value loaded on reset
//   FLUSH_CYCLES squash-window length after a taken jump, legal 1..7
//
// Ports:
//   clk      in   single clock, rising-edge
//   reset_n  in   asynchronous active-low reset
//   bus      pc_ctrl_if.slave  (resolve inputs, fetch outputs)
//
// Build option:
//   PC_RETURN_LINK_EN  when defined, a link register captures PC+1 on every
//                      redirect and drives link_addr; otherwise link_addr
//                      is tied to 0 and no register exists.
// ---------------------------------------------------------------------------
module pc_ctrl #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    FLUSH_CYCLES = 2
) (
    input logic      clk,
    input logic      reset_n,
    pc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    // The counter holds the number of flush cycles still to follow the
    // current one, so it is loaded with FLUSH_CYCLES-1 and the window
    // closes on the edge where it is already 0.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  fetch_valid_q;
    logic                  flush_q;
    logic                  halted_q;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign redirect = bus.is_jmp_op & bus.taken;
    // Natural truncation gives the modulo-2^ADDR_WIDTH wrap.
    assign pc_inc   = pc_q + ADDR_WIDTH'(1);

`ifdef PC_RETURN_LINK_EN
    logic [ADDR_WIDTH-1:0] link_q, link_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state / next-PC logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
`ifdef PC_RETURN_LINK_EN
        link_d  = link_q;
`endif
        unique case (state_q)
            S_BOOT: begin
                // One idle cycle after reset so the first live fetch is
                // RESET_VECTOR itself.
                state_d = S_RUN;
            end
            S_RUN: begin
                // Redirect outranks halt and stall: a halt raised together
                // with a taken jump is dropped and must be re-requested.
                if (redirect) begin
                    pc_d    = bus.jmp_target;
                    cnt_d   = FLUSH_LOAD;
                    state_d = S_FLUSH;
`ifdef PC_RETURN_LINK_EN
                    link_d  = pc_inc;
`endif
                end else if (bus.halt) begin
                    state_d = S_HALT;
                end else if (!bus.stall) begin
                    pc_d = pc_inc;
                end
            end
            S_FLUSH: begin
                // All resolve inputs are ignored; stall does not stretch
                // the window.
                if (cnt_q == 3'd0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, PC and registered outputs (decoded from next state)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_BOOT;
            cnt_q         <= 3'd0;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            fetch_valid_q <= (state_d == S_RUN);
            flush_q       <= (state_d == S_FLUSH);
            halted_q      <= (state_d == S_HALT);
        end
    end

`ifdef PC_RETURN_LINK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end

    assign bus.link_addr = link_q;
`else
    assign bus.link_addr = '0;
`endif

    assign bus.fetch_addr  = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.flush       = flush_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_ctrl
//
// Directed table of resolve inputs with hand-derived expected outputs, a
// hand-written reset-during-flush sequence, then randomized traffic checked
// against a behavioural model that tracks "started / halted / flush cycles
// remaining / PC / link".
// ---------------------------------------------------------------------------
module tb_pc_ctrl;

    localparam int              AW  = 16;
    localparam logic [AW-1:0]   RV  = 16'h0010;
    localparam int              FC  = 2;
    localparam int              NTBL = 26;

    logic clk;
    logic reset_n;

    pc_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    pc_ctrl #(
        .ADDR_WIDTH  (AW),
        .RESET_VECTOR(RV),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Behavioural model
    bit          m_started;
    bit          m_halted;
    int          m_flush_left;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_link;

    typedef struct {
        logic          jmp;
        logic          tk;
        logic [AW-1:0] tgt;
        logic          st;
        logic          hl;
        logic [AW-1:0] ea;
        logic          ev;
        logic          ef;
        logic          eh;
        logic [AW-1:0] el;
    } vec_t;

    vec_t tbl [NTBL];

    function automatic logic [AW-1:0] link_exp(input logic [AW-1:0] v);
`ifdef PC_RETURN_LINK_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_started    = 1'b0;
        m_halted     = 1'b0;
        m_flush_left = 0;
        m_pc         = RV;
        m_link       = '0;
    endtask

    task automatic model_step(input logic jmp, input logic tk,
                              input logic [AW-1:0] tgt,
                              input logic st, input logic hl);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_halted) begin
            // parked
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (jmp && tk) begin
            m_link       = m_pc + 16'd1;
            m_pc         = tgt;
            m_flush_left = FC;
        end else if (hl) begin
            m_halted = 1'b1;
        end else if (!st) begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic check(input string name, input logic [AW-1:0] ea,
                         input logic ev, input logic ef, input logic eh,
                         input logic [AW-1:0] el);
        n_vec++;
        if (bus.fetch_addr !== ea || bus.fetch_valid !== ev ||
            bus.flush !== ef || bus.halted !== eh || bus.link_addr !== el) begin
            n_mis++;
            $display("FAIL %s: got addr=%h valid=%b flush=%b halted=%b link=%h, want addr=%h valid=%b flush=%b halted=%b link=%h",
                     name, bus.fetch_addr, bus.fetch_valid, bus.flush,
                     bus.halted, bus.link_addr, ea, ev, ef, eh, el);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_pc,
              m_started && !m_halted && (m_flush_left == 0),
              (m_flush_left > 0), m_halted, link_exp(m_link));
    endtask

    // Apply inputs, advance one rising edge, leave time 1ns past the edge.
    task automatic step(input logic jmp, input logic tk,
                        input logic [AW-1:0] tgt,
                        input logic st, input logic hl);
        bus.is_jmp_op  = jmp;
        bus.taken      = tk;
        bus.jmp_target = tgt;
        bus.stall      = st;
        bus.halt       = hl;
        @(posedge clk);
        model_step(jmp, tk, tgt, st, hl);
        #1;
    endtask

    task automatic apply_reset(input string name);
        bus.is_jmp_op  = 1'b0;
        bus.taken      = 1'b0;
        bus.jmp_target = '0;
        bus.stall      = 1'b0;
        bus.halt       = 1'b0;
        reset_n        = 1'b0;
        model_reset();
        #1;
        check({name, "_async"}, RV, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        check({name, "_held"}, RV, 1'b0, 1'b0, 1'b0, '0);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- directed table ----------------
        //              jmp  tk   tgt       st   hl   addr      v    f    h    link
        tbl[0]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0010,1'b1,1'b0,1'b0,16'h0000};
        tbl[1]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0011,1'b1,1'b0,1'b0,16'h0000};
        tbl[2]  = '{1'b1,1'b1,16'h0003,1'b0,1'b0,16'h0003,1'b0,1'b1,1'b0,16'h0012};
        tbl[3]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0003,1'b0,1'b1,1'b0,16'h0012};
        tbl[4]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0003,1'b1,1'b0,1'b0,16'h0012};
        tbl[5]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0004,1'b1,1'b0,1'b0,16'h0012};
        tbl[6]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0005,1'b1,1'b0,1'b0,16'h0012};
        tbl[7]  = '{1'b1,1'b1,16'h0040,1'b0,1'b0,16'h0040,1'b0,1'b1,1'b0,16'h0006};
        tbl[8]  = '{1'b1,1'b1,16'h0200,1'b0,1'b0,16'h0040,1'b0,1'b1,1'b0,16'h0006};
        tbl[9]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0040,1'b1,1'b0,1'b0,16'h0006};
        tbl[10] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0041,1'b1,1'b0,1'b0,16'h0006};
        tbl[11] = '{1'b1,1'b0,16'h0300,1'b0,1'b0,16'h0042,1'b1,1'b0,1'b0,16'h0006};
        tbl[12] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0042,1'b1,1'b0,1'b0,16'h0006};
        tbl[13] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0042,1'b1,1'b0,1'b0,16'h0006};
        tbl[14] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0042,1'b1,1'b0,1'b0,16'h0006};
        tbl[15] = '{1'b1,1'b1,16'h0100,1'b1,1'b0,16'h0100,1'b0,1'b1,1'b0,16'h0043};
        tbl[16] = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0100,1'b0,1'b1,1'b0,16'h0043};
        tbl[17] = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0100,1'b1,1'b0,1'b0,16'h0043};
        tbl[18] = '{1'b1,1'b1,16'hFFFE,1'b0,1'b1,16'hFFFE,1'b0,1'b1,1'b0,16'h0101};
        tbl[19] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'hFFFE,1'b0,1'b1,1'b0,16'h0101};
        tbl[20] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'hFFFE,1'b1,1'b0,1'b0,16'h0101};
        tbl[21] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'hFFFF,1'b1,1'b0,1'b0,16'h0101};
        tbl[22] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,16'h0101};
        tbl[23] = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0000,1'b0,1'b0,1'b1,16'h0101};
        tbl[24] = '{1'b1,1'b1,16'h0500,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0101};
        tbl[25] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0101};

        reset_n = 1'b1;
        @(posedge clk);
        #1;
        apply_reset("reset0");
        for (int i = 0; i < NTBL; i++) begin
            step(tbl[i].jmp, tbl[i].tk, tbl[i].tgt, tbl[i].st, tbl[i].hl);
            check($sformatf("tbl[%0d]", i), tbl[i].ea, tbl[i].ev, tbl[i].ef,
                  tbl[i].eh, link_exp(tbl[i].el));
        end

        // ---------------- reset during the second flush cycle ----------------
        apply_reset("reset1");
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("mf_boot", 16'h0010, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0);
        check("mf_flush1", 16'h0077, 1'b0, 1'b1, 1'b0, link_exp(16'h0011));
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("mf_flush2", 16'h0077, 1'b0, 1'b1, 1'b0, link_exp(16'h0011));
        apply_reset("mf_reset");
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("mf_resume0", 16'h0010, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("mf_resume1", 16'h0011, 1'b1, 1'b0, 1'b0, '0);

        // ---------------- randomized traffic vs model ----------------
        apply_reset("reset2");
        for (int i = 0; i < 3000; i++) begin
            logic          r_jmp, r_tk, r_st, r_hl;
            logic [AW-1:0] r_tgt;
            if ($urandom_range(0, 59) == 0) begin
                apply_reset($sformatf("rnd_reset[%0d]", i));
            end
            r_jmp = ($urandom_range(0, 3) == 0);
            r_tk  = 1'($urandom_range(0, 1));
            r_st  = ($urandom_range(0, 3) == 0);
            r_hl  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0)
                r_tgt = 16'hFFFD + 16'($urandom_range(0, 2));
            else
                r_tgt = 16'($urandom);
            step(r_jmp, r_tk, r_tgt, r_st, r_hl);
            check_model($sformatf("rnd[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
